// File: rtl/hd_bitop_seq.sv
// Sequential constant-time bit-manipulation engine: ABS, RMO_OFF, ISO_RMO, NLZ and POPCNT.
// Define HD_BITOP_POPCNT_EN to make opcode 4 (POPCNT) legal; otherwise it is handled as illegal.
module hd_bitop_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned NSlices = WIDTH / STEP;
  localparam int unsigned IdxW    = (NSlices > 1) ? $clog2(NSlices) : 1;
  localparam int unsigned CntW    = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef HD_BITOP_POPCNT_EN
  localparam bit PopEn = 1'b1;
`else
  localparam bit PopEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  scan_q;
  logic [IdxW-1:0]   idx_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              seen_q;
  logic [WIDTH-1:0]  res_q;
  logic              err_q;

  logic              accept;
  logic              in_scan_op;
  logic              last_slice;
  logic [STEP-1:0]   slice;
  logic [CntW-1:0]   slice_lz;
  logic [WIDTH-1:0]  neg_data;
  logic [WIDTH-1:0]  single_res;
  logic              single_err;

  assign accept     = in_valid && in_ready;
  assign in_scan_op = (in_op == 3'd3) || (PopEn && (in_op == 3'd4));
  assign last_slice = (idx_q == IdxW'(NSlices - 1));
  // Operand is shifted left each scan cycle so the current slice is always the top STEP bits.
  assign slice      = scan_q[WIDTH-1 -: STEP];
  assign neg_data   = WIDTH'(0) - in_data;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = in_scan_op ? StScan : StDone;
        end
      end
      StScan: begin
        if (last_slice) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; in_ready is forced low while reset is asserted.
  always_comb begin
    in_ready  = rst_n && (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_data  = res_q;
    out_err   = err_q;
  end

  // Single-step operations, evaluated directly on the accepted operand.
  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (in_op)
      3'd0: begin
        single_res = in_data[WIDTH-1] ? neg_data : in_data;
        single_err = (in_data == MinVal);
      end
      3'd1:    single_res = in_data & (in_data - WIDTH'(1));
      3'd2:    single_res = in_data & neg_data;
      default: single_err = 1'b1;
    endcase
  end

  // Zeros above the first 1 in the current slice (STEP when the slice is empty).
  always_comb begin
    logic hit;
    hit      = 1'b0;
    slice_lz = CntW'(STEP);
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!hit && slice[i]) begin
        slice_lz = CntW'(STEP - 1 - i);
        hit      = 1'b1;
      end
    end
  end

`ifdef HD_BITOP_POPCNT_EN
  logic [CntW-1:0] slice_pop;

  always_comb begin
    slice_pop = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      slice_pop = slice_pop + CntW'(slice[i]);
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (op_q == 3'd3) begin
      if (!seen_q) begin
        cnt_d = cnt_q + slice_lz;
      end
    end else begin
`ifdef HD_BITOP_POPCNT_EN
      cnt_d = cnt_q + slice_pop;
`else
      cnt_d = cnt_q;
`endif
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      seen_q <= 1'b0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q   <= in_op;
            scan_q <= in_data;
            idx_q  <= '0;
            cnt_q  <= '0;
            seen_q <= 1'b0;
            if (!in_scan_op) begin
              res_q <= single_res;
              err_q <= single_err;
            end
          end
        end
        StScan: begin
          scan_q <= scan_q << STEP;
          idx_q  <= idx_q + IdxW'(1);
          cnt_q  <= cnt_d;
          seen_q <= seen_q || (slice != '0);
          if (last_slice) begin
            res_q <= WIDTH'(cnt_d);
            err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd_bitop_seq.sv
// Self-checking bench for hd_bitop_seq: directed vector table, multi-cycle corner cases and
// random operands checked against a behavioural model.
module tb_hd_bitop_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned STEP  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  int total = 0;
  int bad   = 0;

  hd_bitop_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] din;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [31:0] x,
                                output logic [31:0] r, output logic e, output int lat);
    int n;
    longint s;
    r   = 32'd0;
    e   = 1'b0;
    lat = 1;
    case (op)
      3'd0: begin
        if (x == 32'h8000_0000) begin
          r = x;
          e = 1'b1;
        end else begin
          s = longint'($signed(x));
          r = 32'((s < 0) ? -s : s);
        end
      end
      3'd1: r = x & (x - 32'd1);
      3'd2: r = x & (32'd0 - x);
      3'd3: begin
        n = 0;
        for (int i = 31; i >= 0; i--) begin
          if (x[i]) break;
          n++;
        end
        r   = 32'(n);
        lat = WIDTH / STEP + 1;
      end
`ifdef HD_BITOP_POPCNT_EN
      3'd4: begin
        r   = 32'($countones(x));
        lat = WIDTH / STEP + 1;
      end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input int hold,
                        output logic [31:0] r, output logic e, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      in_op    = 3'($urandom);
      in_data  = $urandom;
      lat++;
    end while (!out_valid && lat < 50);
    if (!out_valid) lat = -1;
    repeat (hold) @(negedge clk);
    r = out_data;
    e = out_err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, er;
    logic        e, ee;
    int          lat, el;
    logic [2:0]  op;
    logic [31:0] d;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFB, 32'd5,          1'b0, 1};
    vecs[1]  = '{3'd0, 32'h8000_0000, 32'h8000_0000,  1'b1, 1};
    vecs[2]  = '{3'd1, 32'h0000_00B8, 32'h0000_00B0,  1'b0, 1};
    vecs[3]  = '{3'd2, 32'h0000_00B8, 32'h0000_0008,  1'b0, 1};
    vecs[4]  = '{3'd3, 32'h0001_0000, 32'd15,         1'b0, 9};
    vecs[5]  = '{3'd3, 32'h0000_0000, 32'd32,         1'b0, 9};
    vecs[6]  = '{3'd3, 32'h8000_0000, 32'd0,          1'b0, 9};
`ifdef HD_BITOP_POPCNT_EN
    vecs[7]  = '{3'd4, 32'hF0F0_000F, 32'd12,         1'b0, 9};
`else
    vecs[7]  = '{3'd4, 32'hF0F0_000F, 32'd0,          1'b1, 1};
`endif
    vecs[8]  = '{3'd6, 32'h1234_5678, 32'd0,          1'b1, 1};
    vecs[9]  = '{3'd5, 32'hFFFF_FFFF, 32'd0,          1'b1, 1};
    vecs[10] = '{3'd7, 32'h0000_0001, 32'd0,          1'b1, 1};
    vecs[11] = '{3'd0, 32'h0000_0007, 32'd7,          1'b0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].din, 0, r, e, lat);
      check($sformatf("vec%0d_data", i), r, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Backpressure on an NLZ result with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd3;
    in_data  = 32'h0001_0000;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_op   = 3'd0;
      in_data = 32'hFFFF_FFFF;
      lat++;
    end while (!out_valid && lat < 50);
    check("bp_lat", 32'(lat), 32'd9);
    for (int c = 0; c < 20; c++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'd15);
      check("bp_out_err", 32'(out_err), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    run_op(3'd0, 32'hFFFF_FFF0, 0, r, e, lat);
    check("bp_next_data", r, 32'd16);
    check("bp_next_lat", 32'(lat), 32'd1);

    // Reset during the 4th scan cycle.
    run_op(3'd1, 32'h0000_00F0, 0, r, e, lat);
    @(negedge clk);
    in_valid = 1'b1;
`ifdef HD_BITOP_POPCNT_EN
    in_op    = 3'd4;
`else
    in_op    = 3'd3;
`endif
    in_data  = 32'h00FF_FF00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_out_err", 32'(out_err), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("postrst_no_stale", 32'(out_valid), 32'd0);
    end
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    run_op(3'd0, 32'd7, 0, r, e, lat);
    check("postrst_abs_data", r, 32'd7);
    check("postrst_abs_err", 32'(e), 32'd0);
    check("postrst_abs_lat", 32'(lat), 32'd1);

    // Random operands against the model.
    for (int k = 0; k < 200; k++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       d = 32'd0;
        1:       d = 32'd1 << $urandom_range(0, 31);
        2:       d = 32'h8000_0000;
        3:       d = $urandom >> $urandom_range(0, 31);
        default: d = $urandom;
      endcase
      model(op, d, er, ee, el);
      run_op(op, d, int'($urandom_range(0, 3)), r, e, lat);
      check($sformatf("rand%0d_op%0d_%0h_data", k, op, d), r, er);
      check($sformatf("rand%0d_op%0d_%0h_err", k, op, d), 32'(e), 32'(ee));
      check($sformatf("rand%0d_op%0d_%0h_lat", k, op, d), 32'(lat), 32'(el));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
